nios_nios2_oci_trace_capture: RTL and testbench
===============================================

// Module: nios_nios2_oci_trace_capture
// PURPOSE
//  Parametrised OCI data-capture-trace (DCT) buffer for simulation and on-chip debug.
//  Captures DCT words from the OCI into a DEPTH-entry circular buffer and drains them through a valid/ready read port.
//  Counts dropped or overwritten words and sequences the test-ending handshake into a sticky test_has_ended.
//  Sits beside the OCI debug core; the read side feeds the JTAG/trace readout or a testbench scoreboard.
// PARAMETERS
//  DATA_W     30   width of one DCT word
//  DEPTH      8    buffer entries; power of two, >= 2
//  WRAP_MODE  0    0 = stop-on-full (drop new words); 1 = wrap (overwrite oldest)
//  OVF_W      16   overflow counter width; counter saturates
// PORTS
//  clk             in   1                  clock, all logic rising-edge
//  reset           in   1                  asynchronous, active-high reset
//  capture_en      in   1                  arm capture (level)
//  dct_valid       in   1                  dct_word valid this cycle
//  dct_word        in   DATA_W             DCT word from OCI
//  test_ending     in   1                  request end of test (pulse or level)
//  rd_valid        out  1                  rd_data holds oldest entry
//  rd_ready        in   1                  consumer accepts rd_data
//  rd_data         out  DATA_W             oldest buffered word
//  fill_level      out  $clog2(DEPTH+1)    entries held, 0..DEPTH
//  overflow_count  out  OVF_W              words dropped/overwritten
//  test_has_ended  out  1                  sticky: drain complete after test_ending
// BEHAVIOUR
//  Reset: state=IDLE, pointers=0, fill_level=0, rd_valid=0, rd_data=0, overflow_count=0, test_has_ended=0.
//  States: IDLE -> CAPTURE when capture_en=1. CAPTURE -> DRAIN on test_ending=1.
//  DRAIN -> DONE on the cycle fill_level reaches 0. DONE holds until reset.
//  IDLE -> DRAIN on test_ending as well. capture_en falling in CAPTURE returns to IDLE without clearing the buffer.
//  Write accepted only in CAPTURE with dct_valid=1. Writes in IDLE/DRAIN/DONE are ignored and not counted.
//  Read handshake: pop when rd_valid && rd_ready. rd_valid = (fill_level != 0) in every state.
//  Reads continue in any state.
//  rd_data = mem[rd_ptr], zero-latency from storage; it must be stable while rd_valid && !rd_ready.
//  Write-to-read latency is 1 cycle: a word written at edge N is visible on rd_data after edge N.
//  Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level tracks write minus pop.
//  Full (fill_level=DEPTH) with write and no pop:
//   WRAP_MODE=0: word dropped; overflow_count += 1.
//   WRAP_MODE=1: word stored at wr_ptr; rd_ptr advances (oldest lost); fill stays DEPTH; overflow_count += 1.
//  Full with write and pop in the same cycle: both succeed; fill unchanged; no overflow in either mode.
//  Empty with write and rd_ready: no pop (rd_valid=0); word stored; fill becomes 1.
//  overflow_count saturates at 2^OVF_W-1 and never wraps.
//  test_has_ended rises the cycle after DONE is entered, stays 1 until reset.
//  test_ending repeated in DRAIN/DONE has no effect.
//  Asynchronous reset mid-operation discards all contents; no partial read completes.
// STRUCTURE
//  Shared package nios_oci_trace_pkg: state encoding (IDLE, CAPTURE, DRAIN, DONE) and the WRAP_MODE constants STOP_ON_FULL=0, WRAP=1.
//  One sub-module: nios_oci_trace_ram, a simple dual-port DEPTH x DATA_W register array with synchronous write and asynchronous read.
//  Control FSM, pointers, fill and overflow counter live in the top.
// TESTING (DATA_W=30, DEPTH=8 unless noted)
//  1. capture_en=1; write 0x0000001..0x0000005, rd_ready=0
//     -> fill_level=5, rd_valid=1, rd_data=0x0000001.
//     Then rd_ready=1 for 5 cycles -> reads 1..5 in order, fill=0, rd_valid=0.
//  2. WRAP_MODE=0: write 10 words 0..9, no reads
//     -> fill=8, overflow_count=2, drained sequence 0..7.
//  3. WRAP_MODE=1: write 10 words 0..9, no reads
//     -> fill=8, overflow_count=2, drained sequence 2..9.
//  4. Full buffer, same-cycle write 0x3FFFFFFF and pop
//     -> popped word is the oldest, fill stays 8, overflow_count unchanged, last drained word 0x3FFFFFFF.
//  5. 3 words buffered, pulse test_ending, then dct_valid=1 for 4 cycles
//     -> no writes accepted. Drain 3 words; test_has_ended=1 one cycle after fill hits 0, stays 1.
//  6. Assert reset mid-drain with fill=4
//     -> next cycle fill=0, rd_valid=0, overflow_count=0, test_has_ended=0, state IDLE.
//     OVF_W=2: write 12 words -> overflow_count saturates at 3.

Source files
------------

// File: rtl/nios_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module : nios_oci_trace_pkg
// Brief  : Shared definitions for the OCI data-capture-trace (DCT) buffer:
//          control FSM state encoding and buffer-full policy selectors.
// Rev    : 1.0  initial release
// ============================================================================
package nios_oci_trace_pkg;

   // Control FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Buffer-full policy (WRAP_MODE parameter values)
   localparam int STOP_ON_FULL = 0;
   localparam int WRAP         = 1;

endpackage : nios_oci_trace_pkg
`default_nettype wire

// File: rtl/nios_oci_trace_ram.sv
`default_nettype none
// ============================================================================
// Module : nios_oci_trace_ram
// Brief  : Simple dual-port DEPTH x DATA_W register array. Synchronous write,
//          asynchronous (combinational) read.
// Ports  : clk    - write clock
//          we     - write enable
//          waddr  - write address
//          wdata  - write data
//          raddr  - read address
//          rdata  - read data, combinational from storage
// Rev    : 1.0  initial release
// ============================================================================
module nios_oci_trace_ram
   import nios_oci_trace_pkg::*;
#(
   parameter int DATA_W = 30,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage is not reset: validity is tracked by the owner's fill count.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule : nios_oci_trace_ram
`default_nettype wire

// File: rtl/nios_nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module : nios_nios2_oci_trace_capture
// Brief  : OCI data-capture-trace buffer. Captures DCT words into a DEPTH-entry
//          circular buffer, drains them through a valid/ready read port,
//          counts dropped/overwritten words and sequences the end-of-test
//          handshake into a sticky test_has_ended flag.
// Ports  : clk, reset     - clock; asynchronous active-high reset
//          capture_en     - arm capture (level)
//          dct_valid/word - incoming DCT word
//          test_ending    - end-of-test request
//          rd_valid/ready - read handshake, pop on valid && ready
//          rd_data        - oldest buffered word (0 when empty)
//          fill_level     - entries held, 0..DEPTH
//          overflow_count - dropped/overwritten words, saturating
//          test_has_ended - sticky, set after drain completes
// Rev    : 1.0  initial release
// ============================================================================
module nios_nios2_oci_trace_capture
   import nios_oci_trace_pkg::*;
#(
   parameter int DATA_W    = 30,
   parameter int DEPTH     = 8,
   parameter int WRAP_MODE = STOP_ON_FULL,
   parameter int OVF_W     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       capture_en,
   input  logic                       dct_valid,
   input  logic [DATA_W-1:0]          dct_word,
   input  logic                       test_ending,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [DATA_W-1:0]          rd_data,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic [OVF_W-1:0]           overflow_count,
   output logic                       test_has_ended
);

   localparam int c_ptr_w  = $clog2(DEPTH);
   localparam int c_fill_w = $clog2(DEPTH + 1);

   localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
   localparam logic [c_fill_w-1:0] c_fill_one = c_fill_w'(1);
   localparam logic [c_fill_w-1:0] c_fill_max = c_fill_w'(DEPTH);
   localparam logic [OVF_W-1:0]    c_ovf_one  = OVF_W'(1);
   localparam logic [OVF_W-1:0]    c_ovf_max  = {OVF_W{1'b1}};
   localparam logic                c_wrap     = (WRAP_MODE == WRAP);

   logic [1:0]          r_state;
   logic [1:0]          w_state_next;
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_fill_w-1:0] r_fill;
   logic [c_fill_w-1:0] w_fill_next;
   logic [OVF_W-1:0]    r_ovf;
   logic                r_ended;

   logic                w_full;
   logic                w_accept;
   logic                w_pop;
   logic                w_ovf;
   logic                w_push;
   logic                w_rd_adv;
   logic [DATA_W-1:0]   w_ram_rdata;

   // ------------------------------------------------------------------
   // Datapath decisions
   // ------------------------------------------------------------------
   assign w_full   = (r_fill == c_fill_max);
   assign w_accept = (r_state == ST_CAPTURE) && dct_valid;
   assign w_pop    = rd_valid && rd_ready;
   // A write into a full buffer is only an overflow when no pop frees a slot.
   assign w_ovf    = w_accept && w_full && !w_pop;
   assign w_push   = w_accept && (!w_ovf || c_wrap);
   // In wrap mode an overflowing write evicts the oldest entry.
   assign w_rd_adv = w_pop || (w_ovf && c_wrap);

   always_comb begin
      w_fill_next = r_fill;
      if (w_push && !w_pop && !w_full) begin
         w_fill_next = r_fill + c_fill_one;
      end else if (w_pop && !w_push) begin
         w_fill_next = r_fill - c_fill_one;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (test_ending) begin
               w_state_next = ST_DRAIN;
            end else if (capture_en) begin
               w_state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (test_ending) begin
               w_state_next = ST_DRAIN;
            end else if (!capture_en) begin
               w_state_next = ST_IDLE;
            end
         end
         // DONE is entered on the same edge that empties the buffer.
         ST_DRAIN: begin
            if (w_fill_next == '0) begin
               w_state_next = ST_DONE;
            end
         end
         default: w_state_next = ST_DONE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_ovf    <= '0;
         r_ended  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_fill  <= w_fill_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_ovf && (r_ovf != c_ovf_max)) begin
            r_ovf <= r_ovf + c_ovf_one;
         end
         if (r_state == ST_DONE) begin
            r_ended <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   nios_oci_trace_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_push),
      .waddr (r_wr_ptr),
      .wdata (dct_word),
      .raddr (r_rd_ptr),
      .rdata (w_ram_rdata)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign rd_valid       = (r_fill != '0);
   // Masked so rd_data reads 0 whenever the buffer holds nothing.
   assign rd_data        = rd_valid ? w_ram_rdata : '0;
   assign fill_level     = r_fill;
   assign overflow_count = r_ovf;
   assign test_has_ended = r_ended;

endmodule : nios_nios2_oci_trace_capture
`default_nettype wire

// File: tb/tb_nios_nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_nios_nios2_oci_trace_capture
// Brief  : Self-checking bench. Three instances: index 0 stop-on-full,
//          index 1 wrap, index 2 stop-on-full with a 2-bit overflow counter.
//          Expected read data is queued as words are written and popped as
//          the DUT delivers them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nios_nios2_oci_trace_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset       [3];
   logic        capture_en  [3];
   logic        dct_valid   [3];
   logic [29:0] dct_word    [3];
   logic        test_ending [3];
   logic        rd_ready    [3];

   logic        rd_valid_a  [3];
   logic [29:0] rd_data_a   [3];
   logic [3:0]  fill_a      [3];
   logic        ended_a     [3];
   logic [15:0] ovf0;
   logic [15:0] ovf1;
   logic [1:0]  ovf2;

   nios_nios2_oci_trace_capture #(.DATA_W(30), .DEPTH(8), .WRAP_MODE(0), .OVF_W(16)) u_dut0 (
      .clk(clk), .reset(reset[0]), .capture_en(capture_en[0]), .dct_valid(dct_valid[0]),
      .dct_word(dct_word[0]), .test_ending(test_ending[0]), .rd_valid(rd_valid_a[0]),
      .rd_ready(rd_ready[0]), .rd_data(rd_data_a[0]), .fill_level(fill_a[0]),
      .overflow_count(ovf0), .test_has_ended(ended_a[0]));

   nios_nios2_oci_trace_capture #(.DATA_W(30), .DEPTH(8), .WRAP_MODE(1), .OVF_W(16)) u_dut1 (
      .clk(clk), .reset(reset[1]), .capture_en(capture_en[1]), .dct_valid(dct_valid[1]),
      .dct_word(dct_word[1]), .test_ending(test_ending[1]), .rd_valid(rd_valid_a[1]),
      .rd_ready(rd_ready[1]), .rd_data(rd_data_a[1]), .fill_level(fill_a[1]),
      .overflow_count(ovf1), .test_has_ended(ended_a[1]));

   nios_nios2_oci_trace_capture #(.DATA_W(30), .DEPTH(8), .WRAP_MODE(0), .OVF_W(2)) u_dut2 (
      .clk(clk), .reset(reset[2]), .capture_en(capture_en[2]), .dct_valid(dct_valid[2]),
      .dct_word(dct_word[2]), .test_ending(test_ending[2]), .rd_valid(rd_valid_a[2]),
      .rd_ready(rd_ready[2]), .rd_data(rd_data_a[2]), .fill_level(fill_a[2]),
      .overflow_count(ovf2), .test_has_ended(ended_a[2]));

   int          total = 0;
   int          bad   = 0;
   logic [29:0] exp_q[$];
   int          movf  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ovf_of(input int d);
      case (d)
         0:       return 32'(ovf0);
         1:       return 32'(ovf1);
         default: return 32'(ovf2);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write one word while the instance is capturing; model the expected contents.
   task automatic wr(input int d, input logic [29:0] w);
      int omax;
      omax = (d == 2) ? 3 : 65535;
      dct_valid[d] = 1'b1;
      dct_word[d]  = w;
      if (exp_q.size() < 8) begin
         exp_q.push_back(w);
      end else begin
         if (movf < omax) movf++;
         if (d == 1) begin
            void'(exp_q.pop_front());
            exp_q.push_back(w);
         end
      end
      tick();
      dct_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d, input int n, input string tag);
      logic [29:0] e;
      rd_ready[d] = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 30'h0;
         check({tag, "_rd_valid"}, 32'(rd_valid_a[d]), 32'd1);
         check({tag, "_rd_data"},  32'(rd_data_a[d]),  32'(e));
         tick();
      end
      rd_ready[d] = 1'b0;
   endtask

   task automatic restart_model();
      exp_q.delete();
      movf = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         reset[i] = 1'b1; capture_en[i] = 1'b0; dct_valid[i] = 1'b0;
         dct_word[i] = '0; test_ending[i] = 1'b0; rd_ready[i] = 1'b0;
      end
      tick(); tick();
      for (int i = 0; i < 3; i++) reset[i] = 1'b0;
      tick();

      // Reset state
      check("rst_fill",     32'(fill_a[0]),     32'd0);
      check("rst_rd_valid", 32'(rd_valid_a[0]), 32'd0);
      check("rst_rd_data",  32'(rd_data_a[0]),  32'd0);
      check("rst_ovf",      ovf_of(0),          32'd0);
      check("rst_ended",    32'(ended_a[0]),    32'd0);

      // 1: basic capture and in-order drain
      capture_en[0] = 1'b1;
      tick();
      for (int i = 1; i <= 5; i++) wr(0, 30'(i));
      check("t1_fill",     32'(fill_a[0]),     32'd5);
      check("t1_rd_valid", 32'(rd_valid_a[0]), 32'd1);
      check("t1_rd_data",  32'(rd_data_a[0]),  32'd1);
      drain(0, 5, "t1");
      check("t1_fill_empty",  32'(fill_a[0]),     32'd0);
      check("t1_valid_empty", 32'(rd_valid_a[0]), 32'd0);

      // 2: stop-on-full drops the newest words
      for (int i = 0; i < 10; i++) wr(0, 30'(i));
      check("t2_fill", 32'(fill_a[0]), 32'd8);
      check("t2_ovf",  ovf_of(0),      32'(movf));
      check("t2_ovf2", ovf_of(0),      32'd2);
      drain(0, 8, "t2");

      // 4: full buffer, write and pop in the same cycle
      for (int i = 0; i < 8; i++) wr(0, 30'h100 + 30'(i));
      rd_ready[0]  = 1'b1;
      dct_valid[0] = 1'b1;
      dct_word[0]  = 30'h3FFFFFFF;
      check("t4_pop_oldest", 32'(rd_data_a[0]), 32'(exp_q.pop_front()));
      exp_q.push_back(30'h3FFFFFFF);
      tick();
      rd_ready[0] = 1'b0; dct_valid[0] = 1'b0;
      check("t4_fill", 32'(fill_a[0]), 32'd8);
      check("t4_ovf",  ovf_of(0),      32'd2);
      drain(0, 8, "t4");

      // 5: end of test with buffered words; late writes ignored
      wr(0, 30'h0A); wr(0, 30'h0B); wr(0, 30'h0C);
      test_ending[0] = 1'b1;
      tick();
      test_ending[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dct_valid[0]   = 1'b1;
         dct_word[0]    = 30'h55 + 30'(i);
         test_ending[0] = (i == 1);
         tick();
      end
      dct_valid[0] = 1'b0; test_ending[0] = 1'b0;
      check("t5_fill_ignored", 32'(fill_a[0]), 32'd3);
      drain(0, 3, "t5");
      check("t5_fill_zero",   32'(fill_a[0]),  32'd0);
      check("t5_ended_early", 32'(ended_a[0]), 32'd0);
      tick();
      check("t5_ended", 32'(ended_a[0]), 32'd1);
      test_ending[0] = 1'b1;
      tick(); tick(); tick();
      test_ending[0] = 1'b0;
      check("t5_ended_sticky", 32'(ended_a[0]), 32'd1);

      // 6: asynchronous reset mid-drain
      reset[0] = 1'b1;
      tick();
      reset[0] = 1'b0;
      restart_model();
      capture_en[0] = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) wr(0, 30'h200 + 30'(i));
      test_ending[0] = 1'b1;
      tick();
      test_ending[0] = 1'b0;
      drain(0, 4, "t6");
      check("t6_fill_before", 32'(fill_a[0]), 32'd4);
      check("t6_ovf_before",  ovf_of(0),      32'd2);
      capture_en[0] = 1'b0;
      rd_ready[0]   = 1'b1;
      reset[0]      = 1'b1;
      #1;
      check("t6_rst_fill",     32'(fill_a[0]),     32'd0);
      check("t6_rst_rd_valid", 32'(rd_valid_a[0]), 32'd0);
      check("t6_rst_ovf",      ovf_of(0),          32'd0);
      check("t6_rst_ended",    32'(ended_a[0]),    32'd0);
      tick();
      reset[0] = 1'b0;
      rd_ready[0] = 1'b0;
      restart_model();
      dct_valid[0] = 1'b1; dct_word[0] = 30'h77;
      tick(); tick();
      dct_valid[0] = 1'b0;
      check("t6_idle_no_write", 32'(fill_a[0]),    32'd0);
      check("t6_idle_rd_data",  32'(rd_data_a[0]), 32'd0);
      capture_en[0] = 1'b1;
      tick();
      wr(0, 30'h99);
      check("t6_capture_again", 32'(fill_a[0]),    32'd1);
      check("t6_capture_data",  32'(rd_data_a[0]), 32'h99);
      capture_en[0] = 1'b0;

      // 3: wrap mode overwrites the oldest words
      restart_model();
      capture_en[1] = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) wr(1, 30'(i));
      check("t3_fill", 32'(fill_a[1]), 32'd8);
      check("t3_ovf",  ovf_of(1),      32'd2);
      check("t3_head", 32'(rd_data_a[1]), 32'd2);
      drain(1, 8, "t3");
      check("t3_fill_empty", 32'(fill_a[1]), 32'd0);

      // Overflow counter saturation with a 2-bit counter
      restart_model();
      capture_en[2] = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) wr(2, 30'h300 + 30'(i));
      check("sat_fill",  32'(fill_a[2]), 32'd8);
      check("sat_ovf",   ovf_of(2),      32'(movf));
      check("sat_ovf_3", ovf_of(2),      32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_nios_nios2_oci_trace_capture
`default_nettype wire
